// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the MMIO UART peripheral.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Low address bits of the data and status registers as decoded by the
    // memory controller.
    localparam logic [11:0] UART_DATA_ADDR = 12'h400;
    localparam logic [11:0] UART_STAT_ADDR = 12'h404;

    // Bit positions of the flags within the status word.
    localparam int RX_PRESENT_BIT = 0;
    localparam int TX_FULL_BIT    = 1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head entry is presented
// combinationally on dout; a pop only advances the read pointer.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Full and empty are both judged on the pointers as they stand this
    // cycle, so a same-cycle pop never makes room for a push.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_peripheral.sv
// MMIO UART: TX FIFO feeding an 8N1 serialiser, 8N1 deserialiser feeding
// an RX FIFO, plus the registered read port and sticky overrun flag.
//
// state | meaning (TX FSM)
// IDLE  | waiting for TX FIFO data; pops the head into the shift register
// START | driving the start bit (low) for one bit period
// DATA  | shifting out 8 data bits LSB first, one bit period each
// STOP  | driving the stop bit (high) for one bit period
//
// state | meaning (RX FSM)
// IDLE  | waiting for a low level on the synchronised line
// START | waiting half a bit to re-check the start bit (false-start filter)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit; push the byte if it is high
module uart_mmio_peripheral
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_wen,
    input  logic [7:0] uart_din,
    input  logic       rx_ren,
    output logic [7:0] uart_dout,
    output logic       tx_full,
    output logic       rx_data_present,
    output logic       rx_overrun,
    input  logic       rx,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // FIFO hookups
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       rx_push;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;

    // TX FSM
    uart_state_t tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_line_nxt;

    // RX FSM
    logic [1:0]    rx_sync;
    logic          rx_s;
    uart_state_t rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_wen),
        .din   (uart_din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rx_ren),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_data_present = !rx_empty;
    assign rx_s            = rx_sync[1];

    // TX state, counters and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx       <= tx_line_nxt;
        end
    end

    // TX next-state; the line level is derived from the next state so tx
    // changes on the same edge as the state.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_pop       = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_nxt = '0;
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = tx_head;
                    tx_state_nxt = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_nxt = IDLE;
        endcase

        case (tx_state_nxt)
            START:   tx_line_nxt = 1'b0;
            DATA:    tx_line_nxt = tx_shift_nxt[0];
            default: tx_line_nxt = 1'b1;
        endcase
    end

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx};
    end

    // RX state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    // RX next-state; leaving STOP right after the mid-bit sample gives half a
    // bit of slack to catch a back-to-back start edge.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_push      = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_nxt = '0;
                if (!rx_s) rx_state_nxt = START;
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    if (!rx_s) begin
                        rx_bit_nxt   = '0;
                        rx_state_nxt = DATA;
                    end else begin
                        rx_state_nxt = IDLE;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_push      = rx_s;
                    rx_state_nxt = IDLE;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // Read port: popped byte is held until the next pop; empty pops read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      uart_dout <= 8'h00;
        else if (rx_ren) uart_dout <= rx_empty ? 8'h00 : rx_head;
    end

    // Sticky overrun; a drop in the same cycle as a read keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  rx_overrun <= 1'b0;
        else if (rx_push && rx_full) rx_overrun <= 1'b1;
        else if (rx_ren)             rx_overrun <= 1'b0;
    end

endmodule
